// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, fixed-latency instruction/data memory between the
// fetch stage and the memory stage of the pipeline. Only one access is in
// flight at a time. Data requests have priority. To keep fetch from starving,
// fetch wins one contested grant after STARVE_MAX contested data grants in a
// row. A fetch response can be discarded with if_flush after a branch
// redirect.
//
// Access timeline (grant in cycle T):
//   T               grant (combinational, IDLE only)
//   T+1             ISSUE: mem_cmd/mem_addr/mem_wdata driven for one cycle
//   T+1+MEM_LAT     WAIT with counter at 0: mem_rdata captured
//   T+2+MEM_LAT     back in IDLE: owner's rvalid pulses, next grant possible
//
// Parameters:
//   MEM_LAT     cycles from the mem_cmd cycle to valid mem_rdata (1..7)
//   STARVE_MAX  contested data grants before fetch wins once (1..15)
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   if_req/if_addr    fetch request, held until if_gnt
//   if_flush          drop the outstanding fetch response
//   if_gnt            fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata  fetch response pulse / instruction register
//   d_req/d_we/d_addr/d_wdata  data request, held until d_gnt
//   d_gnt             data accepted this cycle (combinational)
//   d_rvalid/d_rdata  load data or store completion pulse / load register
//   mem_cmd           00 none, 01 load, 10 store
//   mem_addr          word-aligned address, mem_wdata store data
//   mem_rdata         memory read data
//   busy              an access is in flight
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_flush,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic [1:0]  mem_cmd,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_LOAD  = 2'b01;
   localparam logic [1:0] CMD_STORE = 2'b10;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT);

   logic [1:0] state;
   logic [2:0] lat_cnt;
   logic [3:0] starve_cnt;
   logic       owner_data;   // 1 = data stage owns the access, 0 = fetch
   logic       owner_store;
   logic       drop;         // fetch response of this access is discarded

   logic       idle;
   logic       fetch_wins;
   logic       grant_any;
   logic       grant_store;
   logic       capture;
   logic       flush_hit;

   // Byte-offset bits never reach the memory; the name keeps lint quiet.
   logic       unused_addr_lsbs;
   assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

   assign idle = (state == IDLE);

   // Fetch wins when uncontested, or when contested and data has already
   // taken STARVE_MAX contested grants in a row.
   assign fetch_wins = if_req & (~d_req | (starve_cnt == STARVE_LIM));

   // Grants are gated with rst so every output reads 0 while in reset.
   assign if_gnt = rst & idle & fetch_wins;
   assign d_gnt  = rst & idle & d_req & ~fetch_wins;

   assign grant_any   = if_gnt | d_gnt;
   assign grant_store = d_gnt & d_we;

   assign capture   = (state == WAIT) && (lat_cnt == 3'd0);
   assign flush_hit = if_flush & ~owner_data;

   // NOTE: all state updates use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         lat_cnt     <= 3'd0;
         starve_cnt  <= 4'd0;
         owner_data  <= 1'b0;
         owner_store <= 1'b0;
         drop        <= 1'b0;
         busy        <= 1'b0;
         mem_cmd     <= CMD_NONE;
         mem_addr    <= 32'd0;
         mem_wdata   <= 32'd0;
         if_rvalid   <= 1'b0;
         if_rdata    <= 32'd0;
         d_rvalid    <= 1'b0;
         d_rdata     <= 32'd0;
      end else begin
         // Pulse-type outputs default low; the memory command lasts one cycle.
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         mem_cmd   <= CMD_NONE;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;

         case (state)
            IDLE: begin
               if (grant_any) begin
                  state       <= ISSUE;
                  busy        <= 1'b1;
                  lat_cnt     <= LAT_LOAD;
                  owner_data  <= d_gnt;
                  owner_store <= grant_store;
                  mem_cmd     <= grant_store ? CMD_STORE : CMD_LOAD;
                  mem_addr    <= {(d_gnt ? d_addr[31:2] : if_addr[31:2]), 2'b00};
                  mem_wdata   <= grant_store ? d_wdata : 32'd0;
               end
            end

            ISSUE: begin
               state   <= WAIT;
               lat_cnt <= lat_cnt - 3'd1;
               drop    <= drop | flush_hit;
            end

            WAIT: begin
               if (capture) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  drop  <= 1'b0;
                  if (owner_data) begin
                     d_rvalid <= 1'b1;
                     if (!owner_store) begin
                        d_rdata <= mem_rdata;
                     end
                  end else if (!(drop | flush_hit)) begin
                     // A flush in the capture cycle itself still cancels.
                     if_rvalid <= 1'b1;
                     if_rdata  <= mem_rdata;
                  end
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
                  drop    <= drop | flush_hit;
               end
            end

            default: state <= IDLE;
         endcase

         // Anti-starvation counter: counts contested data grants, saturating.
         if (if_gnt) begin
            starve_cnt <= 4'd0;
         end else if (d_gnt && if_req && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. The main instance (MEM_LAT=2,
// STARVE_MAX=4) is checked every cycle against a transaction-level model that
// keeps the grant time of the outstanding access and derives every expected
// output from the timeline T / T+1 / T+1+MEM_LAT / T+2+MEM_LAT. Two extra
// instances with MEM_LAT=1 and 7 cover the latency extremes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int L = 2;
   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   // Main DUT signals
   logic        if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid, busy;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [1:0]  mem_cmd;

   // Latency-sweep instances (fetch port only)
   logic        s_req = 1'b0;
   logic [31:0] s_addr = '0, r1 = '0, r7 = '0;
   logic        u1_if_gnt, u1_if_rvalid, u7_if_gnt, u7_if_rvalid;
   logic [31:0] u1_if_rdata, u7_if_rdata;
   logic        u1_unused_dgnt, u1_unused_dv, u1_unused_busy;
   logic        u7_unused_dgnt, u7_unused_dv, u7_unused_busy;
   logic [31:0] u1_unused_drd, u1_unused_ma, u1_unused_mw;
   logic [31:0] u7_unused_drd, u7_unused_ma, u7_unused_mw;
   logic [1:0]  u1_unused_cmd, u7_unused_cmd;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LAT(L), .STARVE_MAX(S)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(S)) u_lat1 (
      .clk(clk), .rst(rst),
      .if_req(s_req), .if_addr(s_addr), .if_flush(1'b0),
      .if_gnt(u1_if_gnt), .if_rvalid(u1_if_rvalid), .if_rdata(u1_if_rdata),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
      .d_gnt(u1_unused_dgnt), .d_rvalid(u1_unused_dv), .d_rdata(u1_unused_drd),
      .mem_cmd(u1_unused_cmd), .mem_addr(u1_unused_ma), .mem_wdata(u1_unused_mw),
      .mem_rdata(r1), .busy(u1_unused_busy)
   );

   mem_port_arbiter #(.MEM_LAT(7), .STARVE_MAX(S)) u_lat7 (
      .clk(clk), .rst(rst),
      .if_req(s_req), .if_addr(s_addr), .if_flush(1'b0),
      .if_gnt(u7_if_gnt), .if_rvalid(u7_if_rvalid), .if_rdata(u7_if_rdata),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
      .d_gnt(u7_unused_dgnt), .d_rvalid(u7_unused_dv), .d_rdata(u7_unused_drd),
      .mem_cmd(u7_unused_cmd), .mem_addr(u7_unused_ma), .mem_wdata(u7_unused_mw),
      .mem_rdata(r7), .busy(u7_unused_busy)
   );

   // Bookkeeping
   int n_cmp = 0;
   int n_bad = 0;

   // Requester-side intent (held until the model says granted)
   logic        g_if_req = 1'b0, g_flush = 1'b0, g_d_req = 1'b0, g_d_we = 1'b0;
   logic [31:0] g_if_addr = '0, g_d_addr = '0, g_d_wdata = '0;
   logic        rd_good_en = 1'b0;
   logic [31:0] rd_good = '0;

   // Transaction-level reference model
   int          cyc = 0;
   bit          act = 1'b0;     // an access is outstanding
   int          t_g = 0;        // its grant cycle
   bit          own_d = 1'b0, own_st = 1'b0, drop = 1'b0;
   logic [31:0] m_addr = '0, m_wd = '0, cap = '0;
   logic [31:0] e_if_rdata = '0, e_d_rdata = '0;
   int          starve = 0;

   // Observation counters and grant log
   int          n_ifv = 0, n_dv = 0;
   bit          log_en = 1'b0;
   int          gq_t[$];
   bit          gq_d[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      n_cmp++;
      assert (obs === expd) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
      end
   endtask

   task automatic check_zero();
      check("rst_if_gnt",    32'(if_gnt),    32'd0);
      check("rst_d_gnt",     32'(d_gnt),     32'd0);
      check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      check("rst_d_rvalid",  32'(d_rvalid),  32'd0);
      check("rst_if_rdata",  if_rdata,       32'd0);
      check("rst_d_rdata",   d_rdata,        32'd0);
      check("rst_mem_cmd",   32'(mem_cmd),   32'd0);
      check("rst_mem_addr",  mem_addr,       32'd0);
      check("rst_mem_wdata", mem_wdata,      32'd0);
      check("rst_busy",      32'(busy),      32'd0);
   endtask

   // Hold reset for n cycles with random inputs, then release with idle inputs.
   task automatic reset_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst       = 1'b0;
         if_req    = 1'($urandom);
         d_req     = 1'($urandom);
         d_we      = 1'($urandom);
         if_flush  = 1'($urandom);
         if_addr   = $urandom;
         d_addr    = $urandom;
         d_wdata   = $urandom;
         mem_rdata = $urandom;
         #1;
         check_zero();
      end
      @(negedge clk);
      if_req = 1'b0; d_req = 1'b0; if_flush = 1'b0;
      rst    = 1'b1;
      act = 1'b0; drop = 1'b0; starve = 0;
      e_if_rdata = '0; e_d_rdata = '0;
      g_if_req = 1'b0; g_d_req = 1'b0; g_flush = 1'b0;
   endtask

   // One clock cycle: check registered outputs, drive inputs, check grants,
   // advance the model.
   task automatic step();
      bit         gi, gd, e_ifv, e_dv;
      logic [1:0] e_cmd;
      @(negedge clk);
      cyc++;
      e_ifv = 1'b0;
      e_dv  = 1'b0;
      if (act && cyc == t_g + 2 + L) begin
         act = 1'b0;
         if (own_d) begin
            e_dv = 1'b1;
            if (!own_st) e_d_rdata = cap;
         end else if (!drop) begin
            e_ifv = 1'b1;
            e_if_rdata = cap;
         end
         drop = 1'b0;
      end
      e_cmd = (act && cyc == t_g + 1) ? (own_st ? 2'b10 : 2'b01) : 2'b00;
      check("busy",      32'(busy),      32'(act));
      check("mem_cmd",   32'(mem_cmd),   32'(e_cmd));
      if (act && cyc == t_g + 1) begin
         check("mem_addr", mem_addr, m_addr);
         if (own_st) check("mem_wdata", mem_wdata, m_wd);
      end
      check("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
      check("d_rvalid",  32'(d_rvalid),  32'(e_dv));
      check("if_rdata",  if_rdata,       e_if_rdata);
      check("d_rdata",   d_rdata,        e_d_rdata);
      if (if_rvalid) n_ifv++;
      if (d_rvalid)  n_dv++;

      if_req   = g_if_req;  if_addr = g_if_addr; if_flush = g_flush;
      d_req    = g_d_req;   d_we    = g_d_we;
      d_addr   = g_d_addr;  d_wdata = g_d_wdata;
      mem_rdata = (rd_good_en && act && cyc == t_g + 1 + L) ? rd_good : $urandom;
      #1;

      if (act && !own_d && if_flush && cyc >= t_g + 1) drop = 1'b1;
      if (act && cyc == t_g + 1 + L) cap = mem_rdata;

      gi = 1'b0;
      gd = 1'b0;
      if (!act) begin
         if (if_req && d_req) begin
            if (starve == S) gi = 1'b1;
            else             gd = 1'b1;
         end else begin
            gi = if_req;
            gd = d_req;
         end
      end
      check("if_gnt", 32'(if_gnt), 32'(gi));
      check("d_gnt",  32'(d_gnt),  32'(gd));
      if (log_en && (if_gnt || d_gnt)) begin
         gq_t.push_back(cyc);
         gq_d.push_back(d_gnt);
      end

      if (gi || gd) begin
         act    = 1'b1;
         t_g    = cyc;
         own_d  = gd;
         own_st = gd && d_we;
         m_addr = gd ? {d_addr[31:2], 2'b00} : {if_addr[31:2], 2'b00};
         m_wd   = d_wdata;
         drop   = 1'b0;
      end
      if (gi) begin
         starve   = 0;
         g_if_req = 1'b0;
      end
      if (gd) begin
         if (if_req && starve < S) starve++;
         g_d_req = 1'b0;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic rand_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         if (!g_if_req && $urandom_range(0, 2) == 0) begin
            g_if_req  = 1'b1;
            g_if_addr = $urandom;
         end
         if (!g_d_req && $urandom_range(0, 2) == 0) begin
            g_d_req   = 1'b1;
            g_d_we    = 1'($urandom);
            g_d_addr  = $urandom;
            g_d_wdata = $urandom;
         end
         g_flush = ($urandom_range(0, 5) == 0);
         step();
      end
      g_flush = 1'b0;
   endtask

   initial begin
      logic [31:0] old_rd;

      // Reset with random inputs: everything reads 0.
      reset_cycles(4);

      // Single fetch from 0x13, memory returns 0xDEADBEEF.
      g_if_req = 1'b1; g_if_addr = 32'h0000_0013;
      rd_good_en = 1'b1; rd_good = 32'hDEAD_BEEF;
      step();                                        // T
      check("load_gnt_T", 32'(if_gnt), 32'd1);
      step();                                        // T+1
      check("load_cmd_T1",  32'(mem_cmd), 32'd1);
      check("load_addr_T1", mem_addr, 32'h0000_0010);
      step(); step(); step();                        // T+4
      check("load_rvalid_T4", 32'(if_rvalid), 32'd1);
      check("load_rdata_T4",  if_rdata, 32'hDEAD_BEEF);
      check("load_busy_T4",   32'(busy), 32'd0);
      rd_good_en = 1'b0;

      // Store to 0x40.
      g_d_req = 1'b1; g_d_we = 1'b1; g_d_addr = 32'h40; g_d_wdata = 32'h1234_5678;
      step();                                        // T
      step();                                        // T+1
      check("store_cmd_T1",   32'(mem_cmd), 32'd2);
      check("store_wdata_T1", mem_wdata, 32'h1234_5678);
      step(); step(); step();                        // T+4
      check("store_rvalid_T4", 32'(d_rvalid), 32'd1);
      check("store_rdata_kept", d_rdata, 32'd0);

      // Contention: both requests held continuously.
      gq_t.delete(); gq_d.delete();
      log_en = 1'b1;
      for (int i = 0; i < 45; i++) begin
         g_if_req = 1'b1; g_d_req = 1'b1; g_d_we = 1'b0;
         if (i % 4 == 0) begin
            g_if_addr = $urandom; g_d_addr = $urandom;
         end
         step();
      end
      log_en = 1'b0;
      idle_cycles(14);
      check("contend_count_ok", 32'(gq_d.size() >= 10), 32'd1);
      for (int i = 0; i < 10 && i < gq_d.size(); i++) begin
         check("contend_order", 32'(gq_d[i]), 32'((i % 5) != 4));
         if (i > 0) check("contend_spacing", 32'(gq_t[i] - gq_t[i-1]), 32'(L + 2));
      end

      // Flush in a WAIT cycle of a fetch: response dropped, next grant on time.
      old_rd = e_if_rdata;
      n_ifv = 0;
      g_if_req = 1'b1; g_if_addr = $urandom;
      step();                                        // T
      step();                                        // T+1 ISSUE
      g_flush = 1'b1; step(); g_flush = 1'b0;        // T+2 WAIT
      g_d_req = 1'b1; g_d_we = 1'b0; g_d_addr = $urandom;
      step();                                        // T+3
      step();                                        // T+4
      check("flush_next_gnt",    32'(d_gnt), 32'd1);
      check("flush_no_rvalid",   32'(n_ifv), 32'd0);
      check("flush_rdata_kept",  if_rdata, old_rd);
      idle_cycles(6);

      // Flush in the if_rvalid cycle: data still delivered.
      n_ifv = 0;
      g_if_req = 1'b1; g_if_addr = $urandom;
      step(); step(); step(); step();                // T..T+3
      g_flush = 1'b1; step(); g_flush = 1'b0;        // T+4
      idle_cycles(2);
      check("late_flush_rvalid", 32'(n_ifv), 32'd1);

      // Reset in WAIT: aborted access produces no response.
      g_if_req = 1'b1; g_if_addr = $urandom;
      step(); step(); step();                        // T, T+1, T+2
      reset_cycles(2);
      n_ifv = 0; n_dv = 0;
      idle_cycles(8);
      check("abort_no_rvalid", 32'(n_ifv + n_dv), 32'd0);
      g_d_req = 1'b1; g_d_we = 1'b0; g_d_addr = $urandom;
      step();
      check("post_reset_gnt", 32'(d_gnt), 32'd1);
      idle_cycles(6);

      // Randomized traffic against the model.
      rand_cycles(400);
      idle_cycles(12);

      // Latency extremes: MEM_LAT=1 and 7, memory garbage outside sample cycle.
      @(negedge clk);
      s_req = 1'b1; s_addr = $urandom;
      r1 = $urandom; r7 = $urandom;
      #1;
      check("lat1_gnt", 32'(u1_if_gnt), 32'd1);
      check("lat7_gnt", 32'(u7_if_gnt), 32'd1);
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         check("lat1_rvalid", 32'(u1_if_rvalid), 32'(k == 3));
         check("lat7_rvalid", 32'(u7_if_rvalid), 32'(k == 9));
         if (k == 3) check("lat1_rdata", u1_if_rdata, 32'hA1A1_0001);
         if (k == 9) check("lat7_rdata", u7_if_rdata, 32'hB7B7_0007);
         s_req = 1'b0;
         r1 = (k == 2) ? 32'hA1A1_0001 : $urandom;
         r7 = (k == 8) ? 32'hB7B7_0007 : $urandom;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
